// File: rtl/mont_test_sequencer.sv
// Self-test sequencer for a Montgomery multiplier (or any two-operand unit).
// Walks a vector memory of {A, B, expected C} triples, issues each operand
// pair to the unit under test, waits (bounded) for its result, and reports a
// per-vector pass/fail verdict plus run totals.
//
// Ports:
//   clock, reset    single clock, synchronous active-high reset
//   start           run request, honoured only when idle or done
//   rom_addr        vector-memory address (read data returns same cycle)
//   rom_rdata       vector-memory word
//   dut_in_valid    one-cycle operand strobe; dut_A / dut_B operands
//   dut_out_valid   result strobe from the unit; dut_C result
//   busy, done      run status
//   result_valid    one-cycle pulse per completed vector, pass = its verdict
//   vec_idx         current vector index
//   pass_cnt        vectors passed this run (saturating)
//   fail_cnt        vectors failed this run (saturating)
//   timeout_err     sticky, some vector timed out this run
module mont_test_sequencer #(
  parameter int unsigned WIDTH        = 128,
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned NUM_VEC      = 1024,
  parameter int unsigned TIMEOUT      = 4096,
  parameter int unsigned STOP_ON_FAIL = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WIDTH-1:0]  rom_rdata,
  output logic              dut_in_valid,
  output logic [WIDTH-1:0]  dut_A,
  output logic [WIDTH-1:0]  dut_B,
  input  logic              dut_out_valid,
  input  logic [WIDTH-1:0]  dut_C,
  output logic              busy,
  output logic              done,
  output logic              result_valid,
  output logic              pass,
  output logic [15:0]       vec_idx,
  output logic [15:0]       pass_cnt,
  output logic [15:0]       fail_cnt,
  output logic              timeout_err
);

  localparam int unsigned CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [15:0]      LAST_IDX = 16'(NUM_VEC - 1);

  typedef enum logic [2:0] {
    IDLE, LD_A, LD_B, LD_C, ISSUE, WAIT, REPORT, DONE
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  base;      // address of A for the current vector (3k)
  logic [WIDTH-1:0]   c_exp;
  logic [CNT_W-1:0]   wait_cnt;

  // Sequencer: one always_ff, every output registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      base         <= '0;
      rom_addr     <= '0;
      dut_A        <= '0;
      dut_B        <= '0;
      c_exp        <= '0;
      wait_cnt     <= '0;
      dut_in_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      pass         <= 1'b0;
      vec_idx      <= '0;
      pass_cnt     <= '0;
      fail_cnt     <= '0;
      timeout_err  <= 1'b0;
    end else begin
      dut_in_valid <= 1'b0;
      result_valid <= 1'b0;

      unique case (state)
        IDLE, DONE: begin
          rom_addr <= '0;
          if (start) begin
            state       <= LD_A;
            busy        <= 1'b1;
            done        <= 1'b0;
            base        <= '0;
            vec_idx     <= '0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            timeout_err <= 1'b0;
          end
        end

        LD_A: begin
          dut_A    <= rom_rdata;
          rom_addr <= base + ADDR_W'(1);
          state    <= LD_B;
        end

        LD_B: begin
          dut_B    <= rom_rdata;
          rom_addr <= base + ADDR_W'(2);
          state    <= LD_C;
        end

        // Strobe is raised on entry so it is high for the ISSUE cycle only.
        LD_C: begin
          c_exp        <= rom_rdata;
          dut_in_valid <= 1'b1;
          wait_cnt     <= '0;
          state        <= ISSUE;
        end

        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end

        // A result arriving on the last counted cycle still wins over timeout.
        WAIT: begin
          if (dut_out_valid) begin
            pass         <= (dut_C == c_exp);
            result_valid <= 1'b1;
            state        <= REPORT;
          end else if (wait_cnt == CNT_LAST) begin
            pass         <= 1'b0;
            timeout_err  <= 1'b1;
            result_valid <= 1'b1;
            state        <= REPORT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        REPORT: begin
          if (pass) begin
            if (pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
          end else begin
            if (fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
          end
          if ((vec_idx == LAST_IDX) || ((STOP_ON_FAIL != 0) && !pass)) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            rom_addr <= '0;
          end else begin
            vec_idx  <= vec_idx + 16'd1;
            base     <= base + ADDR_W'(3);
            rom_addr <= base + ADDR_W'(3);
            state    <= LD_A;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_test_sequencer.sv
// Bench for mont_test_sequencer: two instances (continue-on-fail and
// stop-on-fail) share a vector memory and a latency-programmable responder.
// Expected issue/result timing, verdicts and totals come from a
// vector-level model of the run.
module tb_mont_test_sequencer;

  localparam int unsigned W   = 32;
  localparam int unsigned AW  = 8;
  localparam int unsigned NV  = 4;
  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start [2];
  logic [AW-1:0] rom_addr [2];
  logic [W-1:0]  rom_rdata [2];
  logic [W-1:0]  dut_a [2];
  logic [W-1:0]  dut_b [2];
  logic [15:0]   vidx [2];
  logic [15:0]   pcnt [2];
  logic [15:0]   fcnt [2];
  logic [1:0]    in_valid, busy, done, rv, pass, terr;
  logic          out_valid = 1'b0;
  logic [W-1:0]  dut_c = '0;

  logic [W-1:0] mem [256];
  int  lat_tab [8];
  bit  cor_tab [8];
  logic sel = 1'b0;
  int  iss_base = 0;
  int  cyc = 0;
  int  n_assert = 0;
  int  n_fail = 0;

  int           iss_cyc [$];
  logic [W-1:0] iss_a [$];
  logic [W-1:0] iss_b [$];
  int           res_cyc [$];
  logic         res_pass [$];
  logic [W-1:0] res_a [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign rom_rdata[g] = mem[rom_addr[g]];
    mont_test_sequencer #(
      .WIDTH(W), .ADDR_W(AW), .NUM_VEC(NV), .TIMEOUT(TMO), .STOP_ON_FAIL(g)
    ) dut (
      .clock(clk), .reset(reset), .start(start[g]),
      .rom_addr(rom_addr[g]), .rom_rdata(rom_rdata[g]),
      .dut_in_valid(in_valid[g]), .dut_A(dut_a[g]), .dut_B(dut_b[g]),
      .dut_out_valid(out_valid), .dut_C(dut_c),
      .busy(busy[g]), .done(done[g]), .result_valid(rv[g]), .pass(pass[g]),
      .vec_idx(vidx[g]), .pass_cnt(pcnt[g]), .fail_cnt(fcnt[g]),
      .timeout_err(terr[g])
    );
  end

  logic         iv_s, rv_s, pass_s;
  logic [W-1:0] a_s, b_s;
  assign iv_s   = in_valid[sel];
  assign rv_s   = rv[sel];
  assign pass_s = pass[sel];
  assign a_s    = dut_a[sel];
  assign b_s    = dut_b[sel];

  // Unit model: C = A + B, answered lat_tab[k] cycles after the issue
  // strobe of vector k (0 = never answers).
  int           pend = 0;
  logic [W-1:0] hold_c = '0;
  always @(posedge clk) begin
    int idx, l;
    out_valid <= 1'b0;
    if (iv_s) begin
      idx = iss_cyc.size() - 1 - iss_base;
      l   = (idx >= 0 && idx < 8) ? lat_tab[idx] : 0;
      hold_c <= a_s + b_s;
      if (l == 1) begin
        out_valid <= 1'b1;
        dut_c     <= a_s + b_s;
        pend      <= 0;
      end else begin
        pend <= (l > 1) ? l - 1 : 0;
      end
    end else if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1) begin
        out_valid <= 1'b1;
        dut_c     <= hold_c;
      end
    end
  end

  // Event recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (iv_s) begin
      iss_cyc.push_back(cyc);
      iss_a.push_back(a_s);
      iss_b.push_back(b_s);
    end
    if (rv_s) begin
      res_cyc.push_back(cyc);
      res_pass.push_back(pass_s);
      res_a.push_back(a_s);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_mem();
    logic [W-1:0] a, b, flip;
    for (int k = 0; k < int'(NV); k++) begin
      a    = $urandom;
      b    = $urandom;
      flip = W'(1) << $urandom_range(W - 1, 0);
      mem[3*k]   = a;
      mem[3*k+1] = b;
      mem[3*k+2] = cor_tab[k] ? ((a + b) ^ flip) : (a + b);
    end
  endtask

  // Run one sequence on instance s and check it against the vector-level model.
  task automatic run(input logic s);
    int ib, rb, c0, n, k, issue, r, l, np, nf, last;
    bit ok, p, to, stop;
    fill_mem();
    sel = s;
    ib = iss_cyc.size();
    rb = res_cyc.size();
    iss_base = ib;
    @(posedge clk); #1;
    start[s] = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start[s] = 1'b0;
    n = 0;
    while (!done[s] && n < 3000) begin @(posedge clk); #1; n++; end
    chk("done_reached", 64'(done[s]), 64'd1);

    r = c0; np = 0; nf = 0; to = 0; k = 0; stop = 0; last = 0;
    while (!stop) begin
      issue = r + 4;
      l  = lat_tab[k];
      ok = (l >= 1) && (l <= int'(TMO));
      r  = issue + (ok ? l : int'(TMO)) + 1;
      p  = ok && !cor_tab[k];
      if (!ok) to = 1;
      if (p) np++; else nf++;
      if (ib + k < iss_cyc.size()) begin
        chk("issue_cycle", 64'(iss_cyc[ib+k]), 64'(issue));
        chk("issue_A", 64'(iss_a[ib+k]), 64'(mem[3*k]));
        chk("issue_B", 64'(iss_b[ib+k]), 64'(mem[3*k+1]));
      end
      if (rb + k < res_cyc.size()) begin
        chk("result_cycle", 64'(res_cyc[rb+k]), 64'(r));
        chk("result_pass", 64'(res_pass[rb+k]), 64'(p));
        chk("A_held_to_report", 64'(res_a[rb+k]), 64'(mem[3*k]));
      end
      last = k;
      stop = (k == int'(NV) - 1) || (s == 1'b1 && !p);
      k++;
    end
    chk("num_issues", 64'(iss_cyc.size() - ib), 64'(k));
    chk("num_results", 64'(res_cyc.size() - rb), 64'(k));
    chk("pass_cnt", 64'(pcnt[s]), 64'(np));
    chk("fail_cnt", 64'(fcnt[s]), 64'(nf));
    chk("timeout_err", 64'(terr[s]), 64'(to));
    chk("vec_idx", 64'(vidx[s]), 64'(last));
    chk("busy_in_done", 64'(busy[s]), 64'd0);
    chk("rom_addr_in_done", 64'(rom_addr[s]), 64'd0);
  endtask

  task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
    lat_tab[0] = l0; lat_tab[1] = l1; lat_tab[2] = l2; lat_tab[3] = l3;
  endtask

  task automatic set_cor(input bit c0, input bit c1, input bit c2, input bit c3);
    cor_tab[0] = c0; cor_tab[1] = c1; cor_tab[2] = c2; cor_tab[3] = c3;
  endtask

  initial begin
    int ib, n, nres;
    start[0] = 1'b0;
    start[1] = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < 8; i++) begin lat_tab[i] = 5; cor_tab[i] = 0; end

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_in_valid", 64'(in_valid), 64'd0);
    chk("rst_result_valid", 64'(rv), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr[0]), 64'd0);
    chk("rst_cnts", 64'({pcnt[0], fcnt[0], vidx[0]}), 64'd0);
    chk("rst_dut_A", 64'(dut_a[0]), 64'd0);

    // All vectors correct, fixed latency 5
    set_lat(5, 5, 5, 5); set_cor(0, 0, 0, 0);
    run(1'b0);
    chk("done_flag", 64'(done[0]), 64'd1);

    // Vector 1 corrupted, continue on fail, random in-range latencies
    set_lat($urandom_range(8, 1), $urandom_range(8, 1), $urandom_range(8, 1), $urandom_range(8, 1));
    set_cor(0, 1, 0, 0);
    run(1'b0);

    // Same stimulus on the stop-on-fail instance
    set_lat(3, 3, 3, 3); set_cor(0, 1, 0, 0);
    run(1'b1);

    // Timeout, answer on the last counted cycle, answer one cycle too late
    set_lat(0, 8, 9, 1); set_cor(0, 0, 0, 0);
    run(1'b0);

    // Random latencies (including never/late) and random corruption
    for (int it = 0; it < 3; it++) begin
      set_lat($urandom_range(12, 0), $urandom_range(12, 0), $urandom_range(12, 0), $urandom_range(12, 0));
      set_cor(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      run(1'b0);
    end

    // Reset during WAIT of vector 1, with its answer arriving afterwards
    set_lat(3, 30, 3, 3); set_cor(0, 0, 0, 0);
    fill_mem();
    sel = 1'b0;
    ib = iss_cyc.size();
    iss_base = ib;
    @(posedge clk); #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    n = 0;
    while (iss_cyc.size() < ib + 2 && n < 200) begin @(posedge clk); #1; n++; end
    chk("reached_vec1_issue", 64'(iss_cyc.size() - ib), 64'd2);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    nres = res_cyc.size();
    chk("midrst_busy", 64'(busy[0]), 64'd0);
    chk("midrst_cnts", 64'({pcnt[0], fcnt[0], vidx[0]}), 64'd0);
    chk("midrst_rom_addr", 64'(rom_addr[0]), 64'd0);
    chk("midrst_dut_A", 64'(dut_a[0]), 64'd0);
    repeat (35) @(posedge clk);
    #1;
    chk("late_answer_ignored", 64'(res_cyc.size() - nres), 64'd0);
    chk("idle_after_late", 64'({busy[0], done[0]}), 64'd0);

    // Fresh run after reset restarts from vector 0
    set_lat(2, 4, 6, 8); set_cor(0, 0, 1, 0);
    run(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mont_test_sequencer.md
MONT_TEST_SEQUENCER -- requirements
Module: mont_test_sequencer

Interface
REQ-001 Parameter WIDTH, default 128: operand/result width in bits.
REQ-002 Parameter ADDR_W, default 15: vector-memory address width.
REQ-003 Parameter NUM_VEC, default 1024: vectors per run, 1..(2^ADDR_W)/3.
REQ-004 Parameter TIMEOUT, default 4096: max cycles waiting for DUT result, >=1.
REQ-005 Parameter STOP_ON_FAIL, default 0: 1 = end run at first failing vector.
REQ-006 clock  in  1  single clock; all state on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 start  in  1  run request, sampled in IDLE or DONE only.
REQ-009 rom_addr  out  ADDR_W  vector-memory address.
REQ-010 rom_rdata  in  WIDTH  memory word for current rom_addr, valid same cycle.
REQ-011 dut_in_valid  out  1  one-cycle operand-valid pulse to DUT.
REQ-012 dut_A / dut_B  out  WIDTH  operands to DUT.
REQ-013 dut_out_valid  in  1  DUT result valid.
REQ-014 dut_C  in  WIDTH  DUT result.
REQ-015 busy  out  1  high in every state except IDLE and DONE.
REQ-016 done  out  1  high while in DONE.
REQ-017 result_valid  out  1  one-cycle pulse per completed vector.
REQ-018 pass  out  1  verdict of that vector, meaningful when result_valid=1.
REQ-019 vec_idx  out  16  index of current vector.
REQ-020 pass_cnt / fail_cnt  out  16 each  vectors passed / failed this run.
REQ-021 timeout_err  out  1  sticky: at least one vector timed out this run.

Function
REQ-022 Memory layout: vector k at 3k (A), 3k+1 (B), 3k+2 (expected C).
REQ-023 States: IDLE, LD_A, LD_B, LD_C, ISSUE, WAIT, REPORT, DONE.
REQ-024 IDLE/DONE: rom_addr=0; start=1 -> LD_A, vec_idx, pass_cnt, fail_cnt, timeout_err cleared.
REQ-025 LD_A: A<=rom_rdata, rom_addr<=3k+1 -> LD_B; LD_B: B likewise, rom_addr<=3k+2 -> LD_C; LD_C: C_exp<=rom_rdata -> ISSUE.
REQ-026 ISSUE: dut_in_valid=1 for exactly this cycle, wait counter cleared -> WAIT; dut_A/dut_B stable from ISSUE through REPORT.
REQ-027 WAIT: dut_out_valid=1 -> C_cal<=dut_C, verdict = (C_cal==C_exp) -> REPORT; else counter increments.
REQ-028 WAIT: counter reaches TIMEOUT-1 with dut_out_valid=0 -> verdict fail, timeout_err<=1 -> REPORT; dut_out_valid in same cycle wins.
REQ-029 REPORT: result_valid=1, pass=verdict, matching counter increments, saturating at 0xFFFF.
REQ-030 REPORT exit: vec_idx==NUM_VEC-1, or STOP_ON_FAIL=1 and fail -> DONE; else vec_idx+1, rom_addr<=3(k+1) -> LD_A.
REQ-031 dut_out_valid outside WAIT ignored; start outside IDLE/DONE ignored.
REQ-032 Latency: start sampled cycle 0 -> dut_in_valid at cycle 4; dut_out_valid sampled cycle t -> result_valid at t+1.
REQ-033 Counters, vec_idx, timeout_err hold their values in DONE until next start or reset.

Reset
REQ-034 reset=1 at any edge, including mid-run: state IDLE, rom_addr=0, A/B/C_exp/C_cal=0, all outputs 0, in-flight vector discarded.
REQ-035 First start accepted on the cycle after reset deasserts.

Verification
REQ-036 NUM_VEC=2, DUT model latency 5, both correct -> dut_in_valid cycle 4, result_valid pass=1 twice, pass_cnt=2, fail_cnt=0, done=1.
REQ-037 Vector 1 expected C corrupted, STOP_ON_FAIL=0, NUM_VEC=3 -> pass pattern 1,0,1, pass_cnt=2, fail_cnt=1.
REQ-038 Same stimulus, STOP_ON_FAIL=1 -> DONE after vector 1, vec_idx=1, fail_cnt=1, no third dut_in_valid.
REQ-039 TIMEOUT=8, DUT never responds -> result_valid 8 cycles after WAIT entry, pass=0, timeout_err=1; out_valid on cycle 8 exactly -> compared normally.
REQ-040 reset asserted during WAIT of vector 1 -> next cycle busy=0, all counters 0, later late dut_out_valid ignored; new start restarts at rom_addr 0.
